// File: rtl/l1d_sram_pkg.sv
// Shared types for the L1D SRAM port front end.
//   RSP_DEPTH : depth of the read-response FIFO (also the read credit limit)
//   grant_e   : which channel owns the SRAM port this cycle
package l1d_sram_pkg;

    localparam int RSP_DEPTH = 2;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_RD,
        GNT_WR
    } grant_e;

endpackage

// File: rtl/sram_port_arb_if.sv
// Bundle of request/response/SRAM-side signals for sram_port_arb.
//   slave  : the arbiter's view (takes requests, drives the SRAM port)
//   master : the client/SRAM view (drives requests, consumes responses)
interface sram_port_arb_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  rd_valid;
    logic                  rd_ready;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  sram_en;
    logic                  sram_rw;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_wdata;
    logic [DATA_WIDTH-1:0] sram_rdata;

    modport slave (
        input  rd_valid, rd_addr, wr_valid, wr_addr, wr_data, rsp_ready, sram_rdata,
        output rd_ready, wr_ready, rsp_valid, rsp_data,
               sram_en, sram_rw, sram_addr, sram_wdata
    );

    modport master (
        output rd_valid, rd_addr, wr_valid, wr_addr, wr_data, rsp_ready, sram_rdata,
        input  rd_ready, wr_ready, rsp_valid, rsp_data,
               sram_en, sram_rw, sram_addr, sram_wdata
    );
endinterface

// File: rtl/rsp_fifo2.sv
// Two-entry synchronous FIFO holding captured SRAM read data.
//   clk, rst_n : clock, async active-low reset (clears storage and pointers)
//   push, din  : write an entry (caller guarantees not full unless popping)
//   pop        : drop the head entry (caller guarantees not empty)
//   dout       : head entry, straight from registered storage
//   full, empty, occ : occupancy status, occ in 0..2
module rsp_fifo2
    import l1d_sram_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic [1:0]            occ
);
    logic [RSP_DEPTH-1:0][DATA_WIDTH-1:0] mem;
    logic                                 wptr;
    logic                                 rptr;
    logic [1:0]                           cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem  <= '0;
            wptr <= 1'b0;
            rptr <= 1'b0;
            cnt  <= 2'd0;
        end else begin
            if (push) begin
                mem[wptr] <= din;
                wptr      <= ~wptr;
            end
            if (pop) rptr <= ~rptr;
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign dout  = mem[rptr];
    assign full  = (cnt == 2'd2);
    assign empty = (cnt == 2'd0);
    assign occ   = cnt;

endmodule

// File: rtl/sram_port_arb.sv
// Single-port SRAM front end: arbitrates a read and a write channel onto one
// sp_sram port and buffers the 1-cycle-latency read data in a 2-entry FIFO.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave modport; rd_*/wr_* requests, rsp_* responses,
//                sram_* drives/receives the attached sp_sram
// Reads are only granted when a FIFO slot is guaranteed, because the SRAM
// returns data unconditionally one cycle after a read grant.
module sram_port_arb
    import l1d_sram_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int MAX_WR_BURST = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    sram_port_arb_if.slave bus
);
    localparam logic [3:0] BURST_MAX = 4'(MAX_WR_BURST);

    grant_e          gnt;
    logic            rd_inflight;
    logic            pri_rd;
    logic [3:0]      burst_cnt;
    logic [3:0]      burst_inc;
    logic            pop;
    logic            rd_elig;
    logic [2:0]      credit_used;
    logic            fifo_full;
    logic            fifo_empty;
    logic [1:0]      fifo_occ;
    logic [DATA_WIDTH-1:0] fifo_dout;

    assign pop = bus.rsp_valid && bus.rsp_ready;

    // Slots committed = stored + one in flight; a same-cycle pop frees one.
    assign credit_used = {1'b0, fifo_occ} + {2'b00, rd_inflight};
    assign rd_elig     = bus.rd_valid && (credit_used < (3'd2 + {2'b00, pop}));

    always_comb begin
        gnt = GNT_NONE;
        if (rst_n) begin
            if (rd_elig && (!bus.wr_valid || pri_rd)) gnt = GNT_RD;
            else if (bus.wr_valid)                    gnt = GNT_WR;
            else if (rd_elig)                         gnt = GNT_RD;
        end
    end

    always_comb begin
        bus.rd_ready   = 1'b0;
        bus.wr_ready   = 1'b0;
        bus.sram_en    = 1'b0;
        bus.sram_rw    = 1'b0;
        bus.sram_addr  = {ADDR_WIDTH{1'b0}};
        bus.sram_wdata = {DATA_WIDTH{1'b0}};
        case (gnt)
            GNT_RD: begin
                bus.rd_ready  = 1'b1;
                bus.sram_en   = 1'b1;
                bus.sram_rw   = 1'b1;
                bus.sram_addr = bus.rd_addr;
            end
            GNT_WR: begin
                bus.wr_ready   = 1'b1;
                bus.sram_en    = 1'b1;
                bus.sram_addr  = bus.wr_addr;
                bus.sram_wdata = bus.wr_data;
            end
            default: ;
        endcase
    end

    assign burst_inc = burst_cnt + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_inflight <= 1'b0;
            burst_cnt   <= 4'd0;
            pri_rd      <= 1'b0;
        end else begin
            rd_inflight <= (gnt == GNT_RD);

            // Count only writes that actually stall an eligible read.
            if (gnt == GNT_RD || !rd_elig) burst_cnt <= 4'd0;
            else if (gnt == GNT_WR)        burst_cnt <= burst_inc;

            // Raise priority as the count hits the limit so the very next
            // cycle goes to the waiting read.
            if (gnt == GNT_RD)
                pri_rd <= 1'b0;
            else if (gnt == GNT_WR && rd_elig && burst_inc == BURST_MAX)
                pri_rd <= 1'b1;
        end
    end

    rsp_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rd_inflight),
        .pop   (pop),
        .din   (bus.sram_rdata),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .occ   (fifo_occ)
    );

    assign bus.rsp_valid = !fifo_empty;
    assign bus.rsp_data  = fifo_dout;

endmodule

// File: tb/tb_sram_port_arb.sv
// Directed bench for sram_port_arb with a behavioural sp_sram attached.
module tb_sram_port_arb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    sram_port_arb_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

    sram_port_arb #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MAX_WR_BURST(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // sp_sram model: write on rw=0, registered read data on rw=1
    logic [7:0] mem [256];
    logic [7:0] rdata;
    always @(posedge clk) begin
        if (bus.sram_en) begin
            if (bus.sram_rw) rdata <= mem[bus.sram_addr];
            else             mem[bus.sram_addr] <= bus.sram_wdata;
        end
    end
    assign bus.sram_rdata = rdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A capture must never land in a full FIFO unless a pop frees a slot.
    always @(negedge clk) begin
        if (rst_n && dut.rd_inflight)
            chk("push_not_full", {31'b0, dut.fifo_full && !(bus.rsp_valid && bus.rsp_ready)}, 32'd0);
    end

    int acc;
    logic [7:0] exp_d;

    initial begin
        bus.rd_valid  = 1'b1;
        bus.rd_addr   = 8'h55;
        bus.wr_valid  = 1'b1;
        bus.wr_addr   = 8'h66;
        bus.wr_data   = 8'h77;
        bus.rsp_ready = 1'b1;

        // Reset: everything forced low even with requests pending
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 0);
        chk("rst_rsp_data", {24'b0, bus.rsp_data}, 0);
        chk("rst_sram_en", {31'b0, bus.sram_en}, 0);
        chk("rst_rd_ready", {31'b0, bus.rd_ready}, 0);
        chk("rst_wr_ready", {31'b0, bus.wr_ready}, 0);
        chk("rst_sram_addr", {24'b0, bus.sram_addr}, 0);
        bus.rd_valid = 1'b0;
        bus.wr_valid = 1'b0;
        tick();
        rst_n = 1'b1;

        // Write 0x10=0xA5, then read it back
        bus.wr_valid = 1'b1; bus.wr_addr = 8'h10; bus.wr_data = 8'hA5;
        @(negedge clk);
        chk("t1_wr_ready", {31'b0, bus.wr_ready}, 1);
        chk("t1_rw_wr", {31'b0, bus.sram_rw}, 0);
        chk("t1_wdata", {24'b0, bus.sram_wdata}, 32'hA5);
        tick();
        bus.wr_valid = 1'b0; bus.rd_valid = 1'b1; bus.rd_addr = 8'h10;
        @(negedge clk);
        chk("t1_rw_rd", {31'b0, bus.sram_rw}, 1);
        chk("t1_rd_ready", {31'b0, bus.rd_ready}, 1);
        tick();
        bus.rd_valid = 1'b0;
        @(negedge clk);
        chk("t1_rsp_early", {31'b0, bus.rsp_valid}, 0);
        tick();
        @(negedge clk);
        chk("t1_rsp_valid", {31'b0, bus.rsp_valid}, 1);
        chk("t1_rsp_data", {24'b0, bus.rsp_data}, 32'hA5);
        tick();
        @(negedge clk);
        chk("t1_rsp_drained", {31'b0, bus.rsp_valid}, 0);

        // Preload 0x01..0x04 with 0x11..0x44
        for (int i = 1; i <= 4; i++) begin
            bus.wr_valid = 1'b1; bus.wr_addr = 8'(i); bus.wr_data = 8'(i * 17);
            @(negedge clk);
            chk("pre_wr_ready", {31'b0, bus.wr_ready}, 1);
            tick();
        end
        bus.wr_valid = 1'b0;

        // Back-to-back reads, one response per cycle
        for (int k = 0; k < 6; k++) begin
            bus.rd_valid = (k < 4);
            bus.rd_addr  = 8'(k + 1);
            @(negedge clk);
            if (k < 4) chk("t2_rd_ready", {31'b0, bus.rd_ready}, 1);
            if (k >= 2) begin
                exp_d = 8'((k - 1) * 17);
                chk("t2_rsp_valid", {31'b0, bus.rsp_valid}, 1);
                chk("t2_rsp_data", {24'b0, bus.rsp_data}, {24'b0, exp_d});
            end
            tick();
        end
        bus.rd_valid = 1'b0;
        @(negedge clk);
        chk("t2_idle", {31'b0, bus.rsp_valid}, 0);
        tick();

        // Backpressure: only two reads fit while the consumer stalls
        bus.rsp_ready = 1'b0;
        bus.rd_valid  = 1'b1;
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            bus.rd_addr = 8'(1 + acc);
            @(negedge clk);
            if (bus.rd_ready) acc++;
            tick();
        end
        bus.rd_addr = 8'(1 + acc);
        @(negedge clk);
        chk("t3_accepted", 32'(acc), 2);
        chk("t3_rd_blocked", {31'b0, bus.rd_ready}, 0);
        chk("t3_occ", {30'b0, dut.fifo_occ}, 2);
        tick();
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) chk("t3_resume", {31'b0, bus.rd_ready}, 1);
            if (k < 3) begin
                exp_d = 8'((k + 1) * 17);
                chk("t3_rsp_valid", {31'b0, bus.rsp_valid}, 1);
                chk("t3_rsp_data", {24'b0, bus.rsp_data}, {24'b0, exp_d});
            end else begin
                chk("t3_empty", {31'b0, bus.rsp_valid}, 0);
            end
            tick();
            bus.rd_valid = 1'b0;
        end

        // Write burst limit: W,W,W,W,R repeating
        bus.rd_valid = 1'b1; bus.rd_addr = 8'h01;
        bus.wr_valid = 1'b1; bus.wr_addr = 8'h30; bus.wr_data = 8'h5A;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t4_burst_rw", {31'b0, bus.sram_rw}, ((k % 5) == 4) ? 32'd1 : 32'd0);
            tick();
        end
        bus.rd_valid = 1'b0; bus.wr_valid = 1'b0;
        repeat (3) tick();

        // Same-address rd/wr: write wins, read sees new data
        bus.wr_valid = 1'b1; bus.wr_addr = 8'h20; bus.wr_data = 8'h00;
        tick();
        bus.wr_data = 8'h7E; bus.rd_valid = 1'b1; bus.rd_addr = 8'h20;
        @(negedge clk);
        chk("t5_wr_wins", {31'b0, bus.wr_ready}, 1);
        chk("t5_rd_wait", {31'b0, bus.rd_ready}, 0);
        tick();
        bus.wr_valid = 1'b0;
        @(negedge clk);
        chk("t5_rd_gnt", {31'b0, bus.rd_ready}, 1);
        tick();
        bus.rd_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("t5_rsp_valid", {31'b0, bus.rsp_valid}, 1);
        chk("t5_rsp_data", {24'b0, bus.rsp_data}, 32'h7E);
        tick();

        // Reset one cycle after a read grant discards it
        bus.rd_valid = 1'b1; bus.rd_addr = 8'h02;
        @(negedge clk);
        chk("t6_rd_gnt", {31'b0, bus.rd_ready}, 1);
        tick();
        bus.wr_valid = 1'b1;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("t6_rst_rsp", {31'b0, bus.rsp_valid}, 0);
            chk("t6_rst_en", {31'b0, bus.sram_en}, 0);
            chk("t6_rst_rd_ready", {31'b0, bus.rd_ready}, 0);
            chk("t6_rst_wr_ready", {31'b0, bus.wr_ready}, 0);
            tick();
        end
        bus.rd_valid = 1'b0; bus.wr_valid = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t6_no_rsp", {31'b0, bus.rsp_valid}, 0);
            tick();
        end
        bus.rd_valid = 1'b1; bus.rd_addr = 8'h02;
        @(negedge clk);
        chk("t6_new_rd", {31'b0, bus.rd_ready}, 1);
        tick();
        bus.rd_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("t6_rsp_valid", {31'b0, bus.rsp_valid}, 1);
        chk("t6_rsp_data", {24'b0, bus.rsp_data}, 32'h22);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
